branch_resolver: RTL and testbench

- Issuing and resolving end of the 2-bit-counter branch predictor's request/result/taken interface.
- Drives `request` for each fetched branch and captures the registered `prediction` one cycle later into an in-order queue of outstanding predictions.
- When execute resolves the oldest branch, drives the predictor's `result`/`taken` training strobe and flags mispredictions.
- On a misprediction, flushes all younger wrong-path entries.

---
 rtl/branch_resolver_if.sv | 35 +++
 rtl/branch_resolver.sv | 121 ++++++++++++
 tb/tb_branch_resolver.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolver_if.sv
// Fetch/predictor/execute-facing bundle of branch_resolver.
// master = fetch/predictor/execute side, slave = the resolver itself.
interface branch_resolver_if #(
  parameter int PTR_W = 2
);
  logic             br_fetch;
  logic             br_ready;
  logic             request;
  logic             prediction;
  logic             pred_valid;
  logic             pred_taken;
  logic             res_valid;
  logic             res_taken;
  logic             result;
  logic             taken;
  logic             mispredict;
  logic             res_err;
  logic [PTR_W:0]   occupancy;

  // Handshake: a branch is accepted in any cycle where br_fetch & br_ready;
  // that cycle is the request to the predictor, whose answer arrives on
  // prediction exactly one cycle later. res_valid has no ready: execute only
  // resolves branches it has seen, and stray strobes are flagged on res_err.
  modport master (
    output br_fetch, prediction, res_valid, res_taken,
    input  br_ready, request, pred_valid, pred_taken, result, taken,
           mispredict, res_err, occupancy
  );

  modport slave (
    input  br_fetch, prediction, res_valid, res_taken,
    output br_ready, request, pred_valid, pred_taken, result, taken,
           mispredict, res_err, occupancy
  );
endinterface

// File: rtl/branch_resolver.sv
// In-order queue of outstanding branch predictions: issue, capture, resolve,
// train and flush. Optional counters via BRANCH_RESOLVER_STATS_EN.
module branch_resolver #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  branch_resolver_if.slave   bus
`ifdef BRANCH_RESOLVER_STATS_EN
  ,
  output logic [15:0]        stat_resolved,
  output logic [15:0]        stat_mispred
`endif
);

  localparam logic [PTR_W+1:0] DEPTH_W = (PTR_W+2)'(DEPTH);

  logic             r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_occ;
  logic             r_cap_pending;
  logic             r_pred_valid;
  logic             r_pred_taken;
  logic             r_result;
  logic             r_taken;
  logic             r_mispredict;
  logic             r_res_err;

  logic [PTR_W+1:0] w_inflight;
  logic             w_ready;
  logic             w_request;
  logic             w_pop;
  logic             w_mis;
  logic             w_push;
  logic [PTR_W:0]   w_occ_nxt;

  // A pending capture already owns a slot, so it counts against DEPTH here.
  assign w_inflight = {1'b0, r_occ} + {{(PTR_W+1){1'b0}}, r_cap_pending};
  assign w_ready    = !r_mispredict && (w_inflight < DEPTH_W);
  assign w_request  = bus.br_fetch && w_ready;
  assign w_pop      = bus.res_valid && (r_occ != '0);
  assign w_mis      = w_pop && (r_mem[r_head] != bus.res_taken);
  assign w_push     = r_cap_pending && !w_mis;

  always_comb begin
    w_occ_nxt = r_occ;
    if (w_mis)
      w_occ_nxt = '0;
    else if (w_push && !w_pop)
      w_occ_nxt = r_occ + (PTR_W+1)'(1);
    else if (!w_push && w_pop)
      w_occ_nxt = r_occ - (PTR_W+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 1'b0;
      r_head        <= '0;
      r_tail        <= '0;
      r_occ         <= '0;
      r_cap_pending <= 1'b0;
      r_pred_valid  <= 1'b0;
      r_pred_taken  <= 1'b0;
      r_result      <= 1'b0;
      r_taken       <= 1'b0;
      r_mispredict  <= 1'b0;
      r_res_err     <= 1'b0;
    end else begin
      r_occ         <= w_occ_nxt;
      r_cap_pending <= w_request && !w_mis;
      r_pred_valid  <= w_push;
      r_pred_taken  <= w_push && bus.prediction;
      r_result      <= w_pop;
      r_taken       <= w_pop && bus.res_taken;
      r_mispredict  <= w_mis;
      r_res_err     <= bus.res_valid && (r_occ == '0);
      if (w_push) begin
        r_mem[r_tail] <= bus.prediction;
        r_tail        <= r_tail + PTR_W'(1);
      end
      // Flush drops every younger entry by collapsing head onto tail.
      if (w_mis)
        r_head <= r_tail;
      else if (w_pop)
        r_head <= r_head + PTR_W'(1);
    end
  end

  assign bus.br_ready   = w_ready;
  assign bus.request    = w_request;
  assign bus.pred_valid = r_pred_valid;
  assign bus.pred_taken = r_pred_taken;
  assign bus.result     = r_result;
  assign bus.taken      = r_taken;
  assign bus.mispredict = r_mispredict;
  assign bus.res_err    = r_res_err;
  assign bus.occupancy  = r_occ;

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [15:0] r_stat_resolved;
  logic [15:0] r_stat_mispred;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_resolved <= '0;
      r_stat_mispred  <= '0;
    end else begin
      if (w_pop && (r_stat_resolved != 16'hFFFF))
        r_stat_resolved <= r_stat_resolved + 16'd1;
      if (w_mis && (r_stat_mispred != 16'hFFFF))
        r_stat_mispred <= r_stat_mispred + 16'd1;
    end
  end

  assign stat_resolved = r_stat_resolved;
  assign stat_mispred  = r_stat_mispred;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed scenarios plus a random
// run against a queue-based reference model.
module tb_branch_resolver;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  branch_resolver_if #(.PTR_W(PTR_W)) bus ();

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [15:0] stat_resolved;
  logic [15:0] stat_mispred;
`endif

  branch_resolver #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    .stat_resolved (stat_resolved),
    .stat_mispred  (stat_mispred)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: outstanding predictions as a queue, oldest first.
  logic [0:0] exp_q[$];
  bit m_cap, m_pv, m_pt, m_res, m_tk, m_mis, m_err;
  int m_sr, m_sm;
  bit e_rdy, e_req, o_rdy, o_req;

  task automatic model_reset();
    exp_q.delete();
    m_cap = 0; m_pv = 0; m_pt = 0; m_res = 0; m_tk = 0; m_mis = 0; m_err = 0;
    m_sr = 0; m_sm = 0;
  endtask

  task automatic model_edge(input bit p, input bit rv, input bit rt);
    bit pop, mis;
    pop   = rv && (exp_q.size() > 0);
    mis   = pop && (exp_q[0] != rt);
    m_err = rv && (exp_q.size() == 0);
    m_res = pop;
    m_tk  = pop && rt;
    m_mis = mis;
    if (pop && m_sr < 65535) m_sr++;
    if (mis && m_sm < 65535) m_sm++;
    if (mis) begin
      exp_q.delete();
      m_pv = 0; m_pt = 0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (m_cap) begin
        exp_q.push_back(p);
        m_pv = 1; m_pt = p;
      end else begin
        m_pv = 0; m_pt = 0;
      end
    end
    m_cap = e_req && !mis;
  endtask

  // One clock: apply inputs, sample combinational outputs before the edge,
  // advance the model at the edge, and return 1 time unit after it.
  task automatic cycle(input bit f, input bit p, input bit rv, input bit rt);
    bus.br_fetch = f; bus.prediction = p; bus.res_valid = rv; bus.res_taken = rt;
    #2;
    e_rdy = !m_mis && ((exp_q.size() + int'(m_cap)) < DEPTH);
    e_req = f && e_rdy;
    o_rdy = bus.br_ready;
    o_req = bus.request;
    @(posedge clk);
    model_edge(p, rv, rt);
    #1;
  endtask

  function automatic logic [8:0] dut_vec();
    return {bus.pred_valid, bus.pred_taken, bus.result, bus.taken,
            bus.mispredict, bus.res_err, bus.occupancy};
  endfunction

  function automatic logic [8:0] model_vec();
    return {m_pv, m_pt, m_res, m_tk, m_mis, m_err, 3'(exp_q.size())};
  endfunction

  task automatic test_reset();
    bus.br_fetch = 0; bus.prediction = 0; bus.res_valid = 0; bus.res_taken = 0;
    #1 rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (dut_vec() !== 9'b0 || bus.br_ready !== 1'b1 || bus.request !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outs: got %b rdy=%b req=%b want 000000000 rdy=1 req=0",
               dut_vec(), bus.br_ready, bus.request);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    cycle(1, 0, 0, 0);
    n_cmp++;
    if (o_req !== 1'b1) begin n_fail++; $display("FAIL single_req: got %b want 1", o_req); end
    cycle(0, 1, 0, 0);
    n_cmp++;
    if (dut_vec() !== 9'b110000_001) begin
      n_fail++; $display("FAIL single_capture: got %b want 110000001", dut_vec());
    end
    cycle(0, 0, 1, 1);
    n_cmp++;
    if (dut_vec() !== 9'b001100_000) begin
      n_fail++; $display("FAIL single_resolve: got %b want 001100000", dut_vec());
    end
    cycle(0, 0, 0, 0);
    n_cmp++;
    if (dut_vec() !== 9'b0) begin
      n_fail++; $display("FAIL single_idle: got %b want 000000000", dut_vec());
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] pats;
    bit rt;
    pats = 5'b11010;
    for (int i = 0; i < 5; i++) begin
      cycle(1, pats[i], 0, 0);
      if (i < 4) begin
        n_cmp++;
        if (o_req !== 1'b1) begin n_fail++; $display("FAIL b2b_req%0d: got %b want 1", i, o_req); end
      end
    end
    n_cmp++;
    if ({o_rdy, o_req} !== 2'b00) begin
      n_fail++; $display("FAIL b2b_full_ready: got rdy/req=%b%b want 00", o_rdy, o_req);
    end
    n_cmp++;
    if (bus.occupancy !== 3'd4) begin
      n_fail++; $display("FAIL b2b_occ_full: got %0d want 4", bus.occupancy);
    end
    for (int i = 0; i < 4; i++) begin
      rt = exp_q[0];
      cycle(0, 0, 1, rt);
      n_cmp++;
      if ({bus.result, bus.taken, bus.mispredict, bus.occupancy} !== {1'b1, rt, 1'b0, 3'(3 - i)}) begin
        n_fail++;
        $display("FAIL b2b_drain%0d: got res/tk/mis/occ=%b%b%b/%0d want 1%b0/%0d",
                 i, bus.result, bus.taken, bus.mispredict, bus.occupancy, rt, 3 - i);
      end
    end
  endtask

  task automatic test_mispredict();
    cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    n_cmp++;
    if (dut_vec() !== 9'b110000_011) begin
      n_fail++; $display("FAIL mis_setup: got %b want 110000011", dut_vec());
    end
    cycle(0, 0, 1, 0);
    n_cmp++;
    if (dut_vec() !== 9'b001010_000) begin
      n_fail++; $display("FAIL mis_flush: got %b want 001010000", dut_vec());
    end
    cycle(1, 0, 0, 0);
    n_cmp++;
    if ({o_rdy, o_req} !== 2'b00) begin
      n_fail++; $display("FAIL mis_bubble: got rdy/req=%b%b want 00", o_rdy, o_req);
    end
    n_cmp++;
    if (dut_vec() !== 9'b0) begin
      n_fail++; $display("FAIL mis_single_pulse: got %b want 000000000", dut_vec());
    end
    cycle(0, 0, 0, 0);
    n_cmp++;
    if (o_rdy !== 1'b1) begin n_fail++; $display("FAIL mis_ready_back: got %b want 1", o_rdy); end
  endtask

  task automatic test_flush_with_request();
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 1, 1, 0);
    n_cmp++;
    if (o_req !== 1'b1) begin n_fail++; $display("FAIL flushreq_req: got %b want 1", o_req); end
    n_cmp++;
    if (dut_vec() !== 9'b001010_000) begin
      n_fail++; $display("FAIL flushreq_flush: got %b want 001010000", dut_vec());
    end
    cycle(0, 1, 0, 0);
    n_cmp++;
    if (dut_vec() !== 9'b0 || o_rdy !== 1'b0) begin
      n_fail++; $display("FAIL flushreq_dropped: got %b rdy=%b want 000000000 rdy=0", dut_vec(), o_rdy);
    end
  endtask

  task automatic test_res_err();
    cycle(0, 0, 1, 1);
    n_cmp++;
    if (dut_vec() !== 9'b000001_000) begin
      n_fail++; $display("FAIL err_empty: got %b want 000001000", dut_vec());
    end
    cycle(1, 0, 0, 0);
    n_cmp++;
    if (dut_vec() !== 9'b0) begin
      n_fail++; $display("FAIL err_clear: got %b want 000000000", dut_vec());
    end
    cycle(0, 1, 1, 1);
    n_cmp++;
    if (dut_vec() !== 9'b110001_001) begin
      n_fail++; $display("FAIL err_pending: got %b want 110001001", dut_vec());
    end
    cycle(0, 0, 1, 1);
    n_cmp++;
    if (dut_vec() !== 9'b001100_000) begin
      n_fail++; $display("FAIL err_then_resolve: got %b want 001100000", dut_vec());
    end
  endtask

  task automatic test_reset_mid();
    cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(1, 0, 0, 0);
    n_cmp++;
    if (bus.occupancy !== 3'd2 || bus.pred_valid !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_setup: got occ=%0d pv=%b want 2 1", bus.occupancy, bus.pred_valid);
    end
    bus.br_fetch = 0; bus.prediction = 0; bus.res_valid = 0; bus.res_taken = 0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (dut_vec() !== 9'b0) begin
      n_fail++; $display("FAIL rstmid_async: got %b want 000000000", dut_vec());
    end
`ifdef BRANCH_RESOLVER_STATS_EN
    n_cmp++;
    if ({stat_resolved, stat_mispred} !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_stats: got %h %h want 0 0", stat_resolved, stat_mispred);
    end
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle(1, 0, 0, 0);
    n_cmp++;
    if ({o_rdy, o_req, dut_vec()} !== 11'b11_000000_000) begin
      n_fail++; $display("FAIL rstmid_fresh_issue: got %b%b %b want 11 000000000", o_rdy, o_req, dut_vec());
    end
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    n_cmp++;
    if (dut_vec() !== 9'b001000_000) begin
      n_fail++; $display("FAIL rstmid_fresh_resolve: got %b want 001000000", dut_vec());
    end
  endtask

  task automatic test_random();
    bit f, p, rv, rt;
    for (int i = 0; i < 400; i++) begin
      f  = ($urandom_range(0, 9) < 7);
      p  = 1'($urandom_range(0, 1));
      rv = ($urandom_range(0, 9) < 4);
      if (exp_q.size() > 0 && $urandom_range(0, 9) < 8) rt = exp_q[0];
      else rt = 1'($urandom_range(0, 1));
      cycle(f, p, rv, rt);
      n_cmp++;
      if ({o_rdy, o_req} !== {e_rdy, e_req}) begin
        n_fail++; $display("FAIL rand_comb[%0d]: got rdy/req=%b%b want %b%b", i, o_rdy, o_req, e_rdy, e_req);
      end
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL rand_outs[%0d]: got %b want %b", i, dut_vec(), model_vec());
      end
`ifdef BRANCH_RESOLVER_STATS_EN
      n_cmp++;
      if (stat_resolved !== 16'(m_sr) || stat_mispred !== 16'(m_sm)) begin
        n_fail++; $display("FAIL rand_stats[%0d]: got %0d %0d want %0d %0d", i, stat_resolved, stat_mispred, m_sr, m_sm);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_mispredict();
    test_flush_with_request();
    test_res_err();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
